disparity_stream_sink: RTL and testbench

- Receiving end of the disparity output interface of the disparity calculation stage (disparity, row_out, col_out, valid).
- Checks raster order of incoming results against internal row/col counters and buffers results in a small FIFO.
- Re-emits results as a ready/valid stream with start-of-frame / end-of-line markers for the frame-store / DMA writer.
- The upstream stage has no backpressure, so this block absorbs downstream stalls and flags overflow instead of stalling.

---
 rtl/disparity_stream_sink.sv | 155 +++++++++++++++
 tb/tb_disparity_stream_sink.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_stream_sink.sv
// disparity_stream_sink
// Receives raster-ordered disparity results from the disparity stage.
// Each result's coordinate is checked against an internal expected
// row/col counter. Each result is tagged with start-of-frame, end-of-line
// and last-pixel flags. It is then buffered in a small first-word-fall-through
// FIFO that feeds a ready/valid stream.
// The upstream stage cannot be stalled. A result that arrives while the
// FIFO is full is dropped, and the sticky overflow flag is set.
//
// Output handshake: a word transfers on every rising clk edge where
// m_valid && m_ready. While m_valid=1 and m_ready=0, m_data/m_sof/m_eol
// hold their values. m_valid never depends combinationally on m_ready.
module disparity_stream_sink #(
   parameter int IMG_ROW    = 200,
   parameter int IMG_COL    = 400,
   parameter int FIFO_DEPTH = 16,
   parameter int DISP_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DISP_W-1:0] in_disparity,
   input  logic [9:0]        in_row,
   input  logic [9:0]        in_col,
   output logic [DISP_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_sof,
   output logic              m_eol,
   output logic              frame_done,
   output logic [4:0]        frame_cnt,
   output logic              err_order,
   output logic              overflow,
   input  logic              clr_status
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = DISP_W + 3;   // {last, eol, sof, disparity}
   localparam logic [9:0]  ROW_LIM  = 10'(IMG_ROW);
   localparam logic [9:0]  COL_LIM  = 10'(IMG_COL);
   localparam logic [9:0]  ROW_LAST = 10'(IMG_ROW - 1);
   localparam logic [9:0]  COL_LAST = 10'(IMG_COL - 1);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   logic [9:0]    exp_row_q, exp_row_d;
   logic [9:0]    exp_col_q, exp_col_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          frame_done_q, frame_done_d;
   logic [4:0]    frame_cnt_q, frame_cnt_d;
   logic          err_order_q, err_order_d;
   logic          overflow_q, overflow_d;

   logic          in_range, coord_match, order_bad;
   logic          tag_sof, tag_eol, tag_last;
   logic [EW-1:0] head;
   logic          fifo_empty, fifo_full, pop, push, drop;

   // Classify the incoming coordinate and derive its tags from the received value
   always_comb begin
      in_range    = (in_row < ROW_LIM) && (in_col < COL_LIM);
      coord_match = (in_row == exp_row_q) && (in_col == exp_col_q);
      order_bad   = in_valid && !(in_range && coord_match);
      tag_sof     = in_range && (in_row == 10'd0) && (in_col == 10'd0);
      tag_eol     = in_range && (in_col == COL_LAST);
      tag_last    = tag_eol && (in_row == ROW_LAST);
   end

   // FIFO flags and handshake; a push into a full FIFO is legal only alongside a pop
   always_comb begin
      head       = mem_q[rd_ptr_q];
      fifo_empty = (cnt_q == '0);
      fifo_full  = (cnt_q == FULL_CNT);
      pop        = !fifo_empty && m_ready;
      push       = in_valid && (!fifo_full || pop);
      drop       = in_valid && !push;
   end

   // Expected coordinate follows the received one, so one glitch reports one error
   always_comb begin
      exp_row_d = exp_row_q;
      exp_col_d = exp_col_q;
      if (in_valid) begin
         if (!in_range) begin
            exp_row_d = 10'd0;
            exp_col_d = 10'd0;
         end else if (in_col == COL_LAST) begin
            exp_col_d = 10'd0;
            exp_row_d = (in_row == ROW_LAST) ? 10'd0 : in_row + 10'd1;
         end else begin
            exp_row_d = in_row;
            exp_col_d = in_col + 10'd1;
         end
      end
   end

   // Pointer/count, frame accounting and sticky status next-state
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + (AW + 1)'(1);
      else if (pop && !push) cnt_d = cnt_q - (AW + 1)'(1);
      frame_done_d = pop && head[EW-1];
      frame_cnt_d  = frame_done_d ? frame_cnt_q + 5'd1 : frame_cnt_q;
      // A new error in the same cycle as a clear keeps the flag set
      err_order_d  = order_bad ? 1'b1 : (clr_status ? 1'b0 : err_order_q);
      overflow_d   = drop      ? 1'b1 : (clr_status ? 1'b0 : overflow_q);
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_row_q    <= '0;
         exp_col_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         err_order_q  <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         exp_row_q    <= exp_row_d;
         exp_col_q    <= exp_col_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         err_order_q  <= err_order_d;
         overflow_q   <= overflow_d;
      end
   end

   // FIFO storage; contents are only meaningful under the count, so no reset
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {tag_last, tag_eol, tag_sof, in_disparity};
   end

   // Head of the FIFO drives the stream; outputs are forced low while empty
   always_comb begin
      m_valid    = !fifo_empty;
      m_data     = m_valid ? head[DISP_W-1:0] : '0;
      m_sof      = m_valid && head[DISP_W];
      m_eol      = m_valid && head[DISP_W+1];
      frame_done = frame_done_q;
      frame_cnt  = frame_cnt_q;
      err_order  = err_order_q;
      overflow   = overflow_q;
   end

endmodule

// File: tb/tb_disparity_stream_sink.sv
// Directed testbench for disparity_stream_sink (2x4 image, 4-entry FIFO).
module tb_disparity_stream_sink;

   localparam int IMG_ROW    = 2;
   localparam int IMG_COL    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int DISP_W     = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic              in_valid = 1'b0;
   logic [DISP_W-1:0] in_disparity = '0;
   logic [9:0]        in_row = '0;
   logic [9:0]        in_col = '0;
   logic              m_ready = 1'b0;
   logic              clr_status = 1'b0;
   logic [DISP_W-1:0] m_data;
   logic              m_valid, m_sof, m_eol, frame_done;
   logic [4:0]        frame_cnt;
   logic              err_order, overflow;

   disparity_stream_sink #(
      .IMG_ROW(IMG_ROW), .IMG_COL(IMG_COL), .FIFO_DEPTH(FIFO_DEPTH), .DISP_W(DISP_W)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_disparity(in_disparity),
      .in_row(in_row), .in_col(in_col), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .err_order(err_order), .overflow(overflow),
      .clr_status(clr_status)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   int n_pop   = 0;
   int n_done  = 0;
   logic [DISP_W+2:0] exp_q[$];   // {last, eol, sof, data}
   logic [DISP_W+2:0] mon_e;
   logic              pend_done = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected tags are derived from the coordinate sent
   function automatic logic [DISP_W+2:0] model(input int r, input int c, input logic [DISP_W-1:0] d);
      logic inr, sof, eol, last;
      inr  = (r < IMG_ROW) && (c < IMG_COL);
      sof  = inr && (r == 0) && (c == 0);
      eol  = inr && (c == IMG_COL - 1);
      last = eol && (r == IMG_ROW - 1);
      return {last, eol, sof, d};
   endfunction

   // Monitor: sampled on the falling edge, where inputs and outputs are settled
   always @(negedge clk) begin
      if (!rst) begin
         pend_done = 1'b0;
      end else begin
         check("frame_done", frame_done, pend_done);
         if (frame_done) n_done++;
         pend_done = 1'b0;
         if (m_valid && m_ready) begin
            n_pop++;
            check("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("m_data", m_data, mon_e[DISP_W-1:0]);
               check("m_sof", m_sof, mon_e[DISP_W]);
               check("m_eol", m_eol, mon_e[DISP_W+1]);
               pend_done = mon_e[DISP_W+2];
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int r, input int c, input logic [DISP_W-1:0] d, input bit keep);
      in_row       = 10'(r);
      in_col       = 10'(c);
      in_disparity = d;
      in_valid     = 1'b1;
      if (keep) exp_q.push_back(model(r, c, d));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic clear_status();
      clr_status = 1'b1;
      tick(1);
      clr_status = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         tick(1);
         k++;
      end
      tick(2);
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      tick(3);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_sof", m_sof, 0);
      check("rst_m_eol", m_eol, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_err_order", err_order, 0);
      check("rst_overflow", overflow, 0);
      rst = 1'b1;
      tick(2);

      // T1: in-order frame, one result every 13 cycles
      m_ready = 1'b1;
      n_pop = 0; n_done = 0;
      for (int r = 0; r < IMG_ROW; r++)
         for (int c = 0; c < IMG_COL; c++) begin
            send(r, c, 32'(r * 16 + c), 1'b1);
            tick(12);
         end
      drain("t1_drain");
      check("t1_words", n_pop, 8);
      check("t1_done_pulses", n_done, 1);
      check("t1_frame_cnt", frame_cnt, 1);
      check("t1_err_order", err_order, 0);
      check("t1_overflow", overflow, 0);

      // T2: stalled output, six back-to-back results overflow a 4-deep FIFO
      m_ready = 1'b0;
      n_pop = 0;
      send(0, 0, 32'h200, 1'b1);
      send(0, 1, 32'h201, 1'b1);
      send(0, 2, 32'h202, 1'b1);
      send(0, 3, 32'h203, 1'b1);
      send(1, 0, 32'h210, 1'b0);
      send(1, 1, 32'h211, 1'b0);
      check("t2_overflow", overflow, 1);
      check("t2_err_order", err_order, 0);
      check("t2_count", dut.cnt_q, 4);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("t2_stall_valid", m_valid, 1);
         check("t2_stall_data", m_data, 32'h200);
         check("t2_stall_sof", m_sof, 1);
      end
      check("t2_count_held", dut.cnt_q, 4);
      m_ready = 1'b1;
      drain("t2_drain");
      check("t2_words", n_pop, 4);
      send(1, 2, 32'h212, 1'b1);
      send(1, 3, 32'h213, 1'b1);
      drain("t2_tail_drain");
      check("t2_err_after_drop", err_order, 0);
      check("t2_frame_cnt", frame_cnt, 2);
      clear_status();
      check("t2_overflow_clr", overflow, 0);

      // T3: order error with resync, then out-of-range coordinates
      n_pop = 0;
      send(0, 0, 32'h300, 1'b1);
      check("t3_err_00", err_order, 0);
      send(0, 1, 32'h301, 1'b1);
      check("t3_err_01", err_order, 0);
      send(0, 3, 32'h303, 1'b1);
      check("t3_err_03", err_order, 1);
      clear_status();
      check("t3_err_clr", err_order, 0);
      send(1, 0, 32'h310, 1'b1);
      check("t3_err_10_resync", err_order, 0);
      send(1, 1, 32'h311, 1'b1);
      send(1, 2, 32'h312, 1'b1);
      send(1, 3, 32'h313, 1'b1);
      drain("t3_drain");
      check("t3_words", n_pop, 7);
      check("t3_frame_cnt", frame_cnt, 3);
      check("t3_err_end", err_order, 0);
      clr_status = 1'b1;
      send(0, 7, 32'h307, 1'b1);
      clr_status = 1'b0;
      check("t3_set_beats_clr", err_order, 1);
      send(2, 3, 32'h323, 1'b1);
      drain("t3_oor_drain");
      clear_status();
      check("t3_oor_clr", err_order, 0);
      for (int r = 0; r < IMG_ROW; r++)
         for (int c = 0; c < IMG_COL; c++)
            send(r, c, 32'h380 + 32'(r * 16 + c), 1'b1);
      check("t3_restart_err", err_order, 0);
      drain("t3_frame_drain");
      check("t3_frame_cnt2", frame_cnt, 4);

      // T4: push and pop in the same cycle while full
      m_ready = 1'b0;
      for (int c = 0; c < IMG_COL; c++) send(0, c, 32'h400 + 32'(c), 1'b1);
      check("t4_full", dut.cnt_q, 4);
      m_ready = 1'b1;
      send(1, 0, 32'h410, 1'b1);
      check("t4_count_first", dut.cnt_q, 4);
      check("t4_overflow_first", overflow, 0);
      send(1, 1, 32'h411, 1'b1);
      send(1, 2, 32'h412, 1'b1);
      send(1, 3, 32'h413, 1'b1);
      check("t4_count_last", dut.cnt_q, 4);
      check("t4_overflow", overflow, 0);
      drain("t4_drain");
      check("t4_frame_cnt", frame_cnt, 5);
      check("t4_err_order", err_order, 0);

      // T5: asynchronous reset mid-frame, then 32 frames to wrap frame_cnt
      m_ready = 1'b0;
      send(0, 0, 32'h500, 1'b1);
      send(0, 1, 32'h501, 1'b1);
      send(0, 2, 32'h502, 1'b1);
      send(0, 3, 32'h503, 1'b1);
      send(1, 0, 32'h510, 1'b0);
      check("t5_pre_overflow", overflow, 1);
      check("t5_pre_valid", m_valid, 1);
      rst = 1'b0;
      #1;
      check("t5_rst_valid", m_valid, 0);
      check("t5_rst_data", m_data, 0);
      check("t5_rst_sof", m_sof, 0);
      check("t5_rst_frame_cnt", frame_cnt, 0);
      check("t5_rst_overflow", overflow, 0);
      check("t5_rst_count", dut.cnt_q, 0);
      exp_q.delete();
      rst = 1'b1;
      tick(1);
      m_ready = 1'b1;
      n_done = 0;
      for (int f = 0; f < 32; f++) begin
         for (int r = 0; r < IMG_ROW; r++)
            for (int c = 0; c < IMG_COL; c++)
               send(r, c, 32'(f * 256 + r * 16 + c), 1'b1);
         if (f == 0) check("t5_restart_err", err_order, 0);
         if (f == 30) begin
            drain("t5_drain31");
            check("t5_frame_cnt31", frame_cnt, 31);
         end
      end
      drain("t5_drain32");
      check("t5_frame_cnt_wrap", frame_cnt, 0);
      check("t5_done_pulses", n_done, 32);
      check("t5_err_order", err_order, 0);
      check("t5_overflow", overflow, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
